// File: rtl/ascii_num_sep_pkg.sv
// Shared types for the ASCII number-separation sequencer: controller states,
// error codes and the payload length qualifier.
package ascii_num_sep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_VALIDATE = 3'd2,
    ST_WAIT_VAL = 3'd3,
    ST_PARSE    = 3'd4,
    ST_FINISH   = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_BAD_LENGTH      = 3'd1,
    ERR_INVALID_CHARS   = 3'd2,
    ERR_RESULT_OVERFLOW = 3'd3,
    ERR_CONVERSION      = 3'd4,
    ERR_TIMEOUT         = 3'd5,
    ERR_COUNT_MISMATCH  = 3'd6
  } err_code_t;

  localparam int DEF_MAX_NUMS        = 1024;
  localparam int DEF_MAX_PAYLOAD     = 1200;
  localparam int DEF_WATCHDOG_CYCLES = 4096;

  // An empty payload is as unusable as an oversized one.
  function automatic logic length_ok(input logic [15:0] len, input int unsigned max_len);
    return (len != 16'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/num_sep_controller_if.sv
// Control, datapath-handshake and result-RAM write signals of the sequencer.
// master = sequencer side, slave = datapath / host side.
interface num_sep_controller_if #(
  parameter int AW = 10
);
  logic          start;
  logic          abort;
  logic [15:0]   total_length;
  logic          val_start;
  logic          val_done;
  logic          val_invalid;
  logic          parse_start;
  logic          parse_clear;
  logic          parse_done;
  logic [10:0]   parse_num_count;
  logic          conv_result_valid;
  logic [31:0]   conv_result;
  logic          conv_error;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [31:0]   res_wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    err_code;
  logic [10:0]   num_total;

  modport master (
    input  start, abort, total_length, val_done, val_invalid, parse_done,
           parse_num_count, conv_result_valid, conv_result, conv_error,
    output val_start, parse_start, parse_clear, res_wr_en, res_wr_addr,
           res_wr_data, busy, done, error, err_code, num_total
  );

  modport slave (
    output start, abort, total_length, val_done, val_invalid, parse_done,
           parse_num_count, conv_result_valid, conv_result, conv_error,
    input  val_start, parse_start, parse_clear, res_wr_en, res_wr_addr,
           res_wr_data, busy, done, error, err_code, num_total
  );
endinterface

// File: rtl/num_sep_watchdog.sv
// Progress watchdog: down-counter reloaded on kick or while disabled;
// expired flags the LIMIT-1'th consecutive enabled cycle without a kick.
module num_sep_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] RELOAD = CW'(LIMIT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (!enable || kick) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // The current idle cycle counts too, hence the reload of LIMIT-2.
  assign expired = enable && !kick && (cnt_q == '0);
endmodule

// File: rtl/num_sep_controller.sv
// Sequencer for validator -> char_stream_parser -> ascii_to_int32: runs one
// payload, streams converted values into the result RAM, reports DONE/ERROR.
//
//   state    | meaning
//   IDLE     | waiting for start, no status
//   CLEAR    | parse_clear pulse
//   VALIDATE | val_start pulse
//   WAIT_VAL | waiting for validator verdict
//   PARSE    | collecting converter results
//   FINISH   | compare parser count with writes
//   DONE     | run completed, num_total valid
//   ERROR    | run failed, err_code valid
module num_sep_controller
  import ascii_num_sep_pkg::*;
#(
  parameter int MAX_NUMS        = DEF_MAX_NUMS,
  parameter int MAX_PAYLOAD     = DEF_MAX_PAYLOAD,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input logic                  clk,
  input logic                  rst_n,
  num_sep_controller_if.master bus
);
  localparam int AW = $clog2(MAX_NUMS);
  localparam int NW = AW + 1;

  ctrl_state_t   state_q, state_d;
  logic [NW-1:0] wr_count_q, wr_count_d, wr_inc;
  logic          val_start_q, val_start_d;
  logic          parse_start_q, parse_start_d;
  logic          parse_clear_q, parse_clear_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  err_code_t     err_q, err_d;
  logic [10:0]   num_total_q, num_total_d;
  logic          fail;
  err_code_t     fail_code;
  logic          wd_enable, wd_kick, wd_expired;

  assign wr_inc    = wr_count_q + NW'(1);
  assign wd_enable = (state_q == ST_WAIT_VAL) || (state_q == ST_PARSE);
  // Every transition between watched states is itself caused by progress.
  assign wd_kick   = bus.val_done || bus.conv_result_valid;

  num_sep_watchdog #(
    .LIMIT(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (wd_enable),
    .kick   (wd_kick),
    .expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    wr_count_d    = wr_count_q;
    val_start_d   = 1'b0;
    parse_start_d = 1'b0;
    parse_clear_d = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = done_q;
    error_d       = error_q;
    err_d         = err_q;
    num_total_d   = num_total_q;
    fail          = 1'b0;
    fail_code     = ERR_NONE;

    if (bus.abort) begin
      if (state_q != ST_IDLE) begin
        state_d       = ST_IDLE;
        parse_clear_d = 1'b1;
        done_d        = 1'b0;
        error_d       = 1'b0;
        err_d         = ERR_NONE;
        num_total_d   = '0;
        wr_count_d    = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start) begin
            done_d      = 1'b0;
            error_d     = 1'b0;
            err_d       = ERR_NONE;
            num_total_d = '0;
            wr_count_d  = '0;
            if (length_ok(bus.total_length, MAX_PAYLOAD)) begin
              state_d       = ST_CLEAR;
              parse_clear_d = 1'b1;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_BAD_LENGTH;
            end
          end
        end
        ST_CLEAR: begin
          state_d     = ST_VALIDATE;
          val_start_d = 1'b1;
        end
        ST_VALIDATE: state_d = ST_WAIT_VAL;
        ST_WAIT_VAL: begin
          if (bus.val_done) begin
            if (bus.val_invalid) begin
              fail      = 1'b1;
              fail_code = ERR_INVALID_CHARS;
            end else begin
              state_d       = ST_PARSE;
              parse_start_d = 1'b1;
            end
          end else if (wd_expired) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
          end
        end
        ST_PARSE: begin
          if (bus.conv_result_valid) begin
            if (bus.conv_error) begin
              fail      = 1'b1;
              fail_code = ERR_CONVERSION;
            end else if (wr_count_q == NW'(MAX_NUMS)) begin
              fail      = 1'b1;
              fail_code = ERR_RESULT_OVERFLOW;
            end else begin
              wr_en_d     = 1'b1;
              wr_addr_d   = wr_count_q[AW-1:0];
              wr_data_d   = bus.conv_result;
              wr_count_d  = wr_inc;
              num_total_d = 11'(wr_inc);
              if (bus.parse_done) state_d = ST_FINISH;
            end
          end else if (bus.parse_done) begin
            state_d = ST_FINISH;
          end else if (wd_expired) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
          end
        end
        ST_FINISH: begin
          if (32'(bus.parse_num_count) != 32'(wr_count_q)) begin
            fail      = 1'b1;
            fail_code = ERR_COUNT_MISMATCH;
          end else begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            num_total_d = 11'(wr_count_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (fail) begin
      state_d       = ST_ERROR;
      error_d       = 1'b1;
      err_d         = fail_code;
      parse_clear_d = 1'b1;
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_count_q    <= '0;
      val_start_q   <= 1'b0;
      parse_start_q <= 1'b0;
      parse_clear_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_q         <= ERR_NONE;
      num_total_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      val_start_q   <= val_start_d;
      parse_start_q <= parse_start_d;
      parse_clear_q <= parse_clear_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_q         <= err_d;
      num_total_q   <= num_total_d;
    end
  end

  assign bus.val_start   = val_start_q;
  assign bus.parse_start = parse_start_q;
  assign bus.parse_clear = parse_clear_q;
  assign bus.res_wr_en   = wr_en_q;
  assign bus.res_wr_addr = wr_addr_q;
  assign bus.res_wr_data = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_q;
  assign bus.num_total   = num_total_q;
endmodule

// File: tb/tb_num_sep_controller.sv
// Bench for num_sep_controller (MAX_NUMS=4, WATCHDOG_CYCLES=16): directed scenarios plus
// randomized runs checked against an outcome model of the sequencing rules.
module tb_num_sep_controller;
  localparam int MAXN = 4;
  localparam int MAXP = 1200;
  localparam int WDC  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  num_sep_controller_if #(.AW(2)) bus ();

  num_sep_controller #(
    .MAX_NUMS(MAXN), .MAX_PAYLOAD(MAXP), .WATCHDOG_CYCLES(WDC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // scenario description
  int sc_len;
  bit sc_invalid;
  int sc_vals[$];
  int sc_err_idx;
  int sc_pnc;
  bit sc_same;
  bit sc_stall;
  int sc_abort_after;

  // observation logs
  int cyc = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int drv_cyc[$];
  int ps_cnt = 0;
  int pc_cnt = 0;
  int last_ps_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_wr_en) begin
        log_addr.push_back(int'(bus.res_wr_addr));
        log_data.push_back(int'(bus.res_wr_data));
        log_cyc.push_back(cyc);
      end
      if (bus.parse_start) begin
        ps_cnt++;
        last_ps_cyc = cyc;
      end
      if (bus.parse_clear) pc_cnt++;
    end
  end

  // Outcome model: expected error code and number of RAM writes.
  function automatic void model_run(output int code, output int nw);
    code = 0;
    nw = 0;
    if (sc_len == 0 || sc_len > MAXP) code = 1;
    else if (sc_invalid) code = 2;
    else begin
      foreach (sc_vals[i]) begin
        if (code == 0) begin
          if (i == sc_err_idx) code = 4;
          else if (nw == MAXN) code = 3;
          else nw++;
        end
      end
      if (code == 0 && sc_pnc != nw) code = 6;
    end
  endfunction

  task automatic set_sc(input int len, input bit inv, input int n, input int err,
                        input int pnc, input bit same);
    sc_len = len;
    sc_invalid = inv;
    sc_err_idx = err;
    sc_pnc = pnc;
    sc_same = same;
    sc_stall = 1'b0;
    sc_abort_after = -1;
    sc_vals.delete();
    for (int i = 0; i < n; i++) sc_vals.push_back(int'($urandom));
  endtask

  task automatic drive_run(output bit to);
    int k;
    to = 1'b0;
    drv_cyc.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.total_length = 16'(sc_len);
    @(negedge clk);
    bus.start = 1'b0;
    if (sc_len != 0 && sc_len <= MAXP) begin
      k = 0;
      while (!bus.val_start && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k == 20) to = 1'b1;
      repeat (1 + $urandom_range(0, 3)) @(negedge clk);
      bus.val_done = 1'b1;
      bus.val_invalid = sc_invalid;
      @(negedge clk);
      bus.val_done = 1'b0;
      bus.val_invalid = 1'b0;
      if (!sc_invalid) begin
        foreach (sc_vals[i]) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          bus.conv_result_valid = 1'b1;
          bus.conv_result = 32'(sc_vals[i]);
          bus.conv_error = (i == sc_err_idx);
          if (sc_same && i == sc_vals.size() - 1) begin
            bus.parse_done = 1'b1;
            bus.parse_num_count = 11'(sc_pnc);
          end
          drv_cyc.push_back(cyc);
          @(negedge clk);
          bus.conv_result_valid = 1'b0;
          bus.conv_error = 1'b0;
          if (i == sc_abort_after) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            return;
          end
        end
        if (!sc_stall && !(sc_same && sc_vals.size() > 0)) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          bus.parse_done = 1'b1;
          bus.parse_num_count = 11'(sc_pnc);
        end
      end
    end
    k = 0;
    while (!bus.done && !bus.error && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done && !bus.error) to = 1'b1;
    bus.parse_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", bus.error); end
    checks++; if (bus.err_code !== 3'd0) begin failures++; $display("FAIL reset_err_code: got %0d want 0", bus.err_code); end
    checks++; if (bus.num_total !== 11'd0) begin failures++; $display("FAIL reset_num_total: got %0d want 0", bus.num_total); end
    checks++;
    if ({bus.val_start, bus.parse_start, bus.parse_clear, bus.res_wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b want 0000", {bus.val_start, bus.parse_start, bus.parse_clear, bus.res_wr_en});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal();
    int base;
    bit to;
    set_sc(9, 0, 0, -1, 3, 0);
    sc_vals.push_back(12);
    sc_vals.push_back(-7);
    sc_vals.push_back(300);
    base = log_addr.size();
    drive_run(to);
    #1;
    checks++; if (to) begin failures++; $display("FAIL normal_timeout: got timeout want done"); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL normal_done: got %b want 1", bus.done); end
    checks++; if (bus.err_code !== 3'd0) begin failures++; $display("FAIL normal_err_code: got %0d want 0", bus.err_code); end
    checks++; if (bus.num_total !== 11'd3) begin failures++; $display("FAIL normal_num_total: got %0d want 3", bus.num_total); end
    checks++; if (log_addr.size() - base !== 3) begin failures++; $display("FAIL normal_writes: got %0d want 3", log_addr.size() - base); end
    for (int j = 0; j < 3 && base + j < log_addr.size(); j++) begin
      checks++; if (log_addr[base+j] !== j) begin failures++; $display("FAIL normal_addr%0d: got %0d want %0d", j, log_addr[base+j], j); end
      checks++; if (log_data[base+j] !== sc_vals[j]) begin failures++; $display("FAIL normal_data%0d: got %0d want %0d", j, log_data[base+j], sc_vals[j]); end
      checks++; if (log_cyc[base+j] !== drv_cyc[j] + 1) begin failures++; $display("FAIL normal_latency%0d: got %0d want 1", j, log_cyc[base+j] - drv_cyc[j]); end
    end
  endtask

  task automatic test_invalid();
    int pbase, cbase;
    bit to;
    set_sc(20, 1, 2, -1, 2, 0);
    pbase = ps_cnt;
    cbase = pc_cnt;
    drive_run(to);
    #1;
    checks++; if (to) begin failures++; $display("FAIL invalid_timeout: got timeout want error"); end
    checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL invalid_error: got %b want 1", bus.error); end
    checks++; if (bus.err_code !== 3'd2) begin failures++; $display("FAIL invalid_err_code: got %0d want 2", bus.err_code); end
    checks++; if (bus.parse_clear !== 1'b1) begin failures++; $display("FAIL invalid_entry_clear: got %b want 1", bus.parse_clear); end
    checks++; if (ps_cnt - pbase !== 0) begin failures++; $display("FAIL invalid_parse_start: got %0d want 0", ps_cnt - pbase); end
    checks++; if (pc_cnt - cbase !== 2) begin failures++; $display("FAIL invalid_parse_clears: got %0d want 2", pc_cnt - cbase); end
  endtask

  task automatic test_overflow();
    int base;
    bit to;
    set_sc(30, 0, 5, -1, 5, 0);
    base = log_addr.size();
    drive_run(to);
    #1;
    checks++; if (to) begin failures++; $display("FAIL ovf_timeout: got timeout want error"); end
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd3) begin failures++; $display("FAIL ovf_code: got err=%b code=%0d want err=1 code=3", bus.error, bus.err_code); end
    checks++; if (bus.num_total !== 11'd4) begin failures++; $display("FAIL ovf_num_total: got %0d want 4", bus.num_total); end
    checks++; if (log_addr.size() - base !== 4) begin failures++; $display("FAIL ovf_writes: got %0d want 4", log_addr.size() - base); end
    checks++; if (log_addr.size() > base + 3 && log_data[base+3] !== sc_vals[3]) begin failures++; $display("FAIL ovf_last_data: got %0d want %0d", log_data[base+3], sc_vals[3]); end
  endtask

  task automatic test_same_cycle();
    int base;
    bit to;
    set_sc(50, 0, 2, -1, 2, 1);
    base = log_addr.size();
    drive_run(to);
    #1;
    checks++; if (to || bus.done !== 1'b1) begin failures++; $display("FAIL same_done: got done=%b to=%b want done=1", bus.done, to); end
    checks++; if (log_addr.size() - base !== 2) begin failures++; $display("FAIL same_writes: got %0d want 2", log_addr.size() - base); end
    checks++;
    if (log_addr.size() > base + 1 && (log_data[base+1] !== sc_vals[1] || log_addr[base+1] !== 1)) begin
      failures++;
      $display("FAIL same_last_write: got addr=%0d data=%0d want addr=1 data=%0d", log_addr[base+1], log_data[base+1], sc_vals[1]);
    end
    checks++; if (bus.num_total !== 11'd2) begin failures++; $display("FAIL same_num_total: got %0d want 2", bus.num_total); end
  endtask

  task automatic test_stall();
    int pbase;
    bit to;
    set_sc(7, 0, 0, -1, 0, 0);
    sc_stall = 1'b1;
    pbase = ps_cnt;
    drive_run(to);
    #1;
    checks++; if (to) begin failures++; $display("FAIL stall_timeout: got no error want error"); end
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd5) begin failures++; $display("FAIL stall_code: got err=%b code=%0d want err=1 code=5", bus.error, bus.err_code); end
    checks++; if (ps_cnt - pbase !== 1) begin failures++; $display("FAIL stall_parse_start: got %0d want 1", ps_cnt - pbase); end
    checks++; if (cyc - last_ps_cyc !== WDC - 1) begin failures++; $display("FAIL stall_latency: got %0d want %0d", cyc - last_ps_cyc, WDC - 1); end
  endtask

  task automatic test_abort();
    int base;
    bit to;
    set_sc(15, 0, 3, -1, 3, 0);
    sc_abort_after = 0;
    drive_run(to);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin failures++; $display("FAIL abort_status: got busy=%b done=%b error=%b want 000", bus.busy, bus.done, bus.error); end
    checks++; if (bus.parse_clear !== 1'b1) begin failures++; $display("FAIL abort_clear: got %b want 1", bus.parse_clear); end
    checks++; if (bus.num_total !== 11'd0 || bus.err_code !== 3'd0) begin failures++; $display("FAIL abort_counts: got num=%0d code=%0d want 0 0", bus.num_total, bus.err_code); end
    repeat (3) @(negedge clk);
    set_sc(15, 0, 2, -1, 2, 0);
    base = log_addr.size();
    drive_run(to);
    #1;
    checks++; if (to || bus.done !== 1'b1) begin failures++; $display("FAIL abort_rerun_done: got done=%b to=%b want done=1", bus.done, to); end
    checks++; if (log_addr.size() - base !== 2) begin failures++; $display("FAIL abort_rerun_writes: got %0d want 2", log_addr.size() - base); end
    checks++; if (log_addr.size() > base && log_addr[base] !== 0) begin failures++; $display("FAIL abort_rerun_addr: got %0d want 0", log_addr[base]); end
  endtask

  task automatic test_random_runs();
    int base, pbase, code, nw, n, r;
    bit to;
    for (int it = 0; it < 30; it++) begin
      case (it)
        0: set_sc(0, 0, 2, -1, 2, 0);
        1: set_sc(MAXP + 1, 0, 2, -1, 2, 0);
        2: set_sc(MAXP, 0, 2, -1, 2, 0);
        3: set_sc(40, 0, 3, -1, 2, 0);
        4: set_sc(40, 0, 3, 1, 3, 0);
        default: begin
          r = $urandom_range(0, 9);
          n = $urandom_range(0, 5);
          set_sc((r == 0) ? 0 : (r == 1) ? MAXP + 1 + $urandom_range(0, 60000) : 1 + $urandom_range(0, MAXP - 1),
                 ($urandom_range(0, 4) == 0),
                 n,
                 (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : ((n > MAXN) ? MAXN : n),
                 $urandom_range(0, 1) == 1);
        end
      endcase
      model_run(code, nw);
      base = log_addr.size();
      pbase = ps_cnt;
      drive_run(to);
      #1;
      checks++; if (to) begin failures++; $display("FAIL rnd%0d_timeout: got timeout want end state", it); end
      checks++; if (bus.err_code !== 3'(code)) begin failures++; $display("FAIL rnd%0d_err_code: got %0d want %0d", it, bus.err_code, code); end
      checks++; if (bus.done !== (code == 0) || bus.error !== (code != 0)) begin failures++; $display("FAIL rnd%0d_status: got done=%b error=%b want code %0d", it, bus.done, bus.error, code); end
      checks++; if (int'(bus.num_total) !== nw) begin failures++; $display("FAIL rnd%0d_num_total: got %0d want %0d", it, bus.num_total, nw); end
      checks++; if (log_addr.size() - base !== nw) begin failures++; $display("FAIL rnd%0d_writes: got %0d want %0d", it, log_addr.size() - base, nw); end
      for (int j = 0; j < nw && base + j < log_addr.size(); j++) begin
        checks++;
        if (log_addr[base+j] !== j || log_data[base+j] !== sc_vals[j] || log_cyc[base+j] !== drv_cyc[j] + 1) begin
          failures++;
          $display("FAIL rnd%0d_write%0d: got addr=%0d data=%0d lat=%0d want addr=%0d data=%0d lat=1",
                   it, j, log_addr[base+j], log_data[base+j], log_cyc[base+j] - drv_cyc[j], j, sc_vals[j]);
        end
      end
      checks++; if (ps_cnt - pbase !== ((code == 1 || code == 2) ? 0 : 1)) begin failures++; $display("FAIL rnd%0d_parse_start: got %0d pulses for code %0d", it, ps_cnt - pbase, code); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy: got %b want 0", it, bus.busy); end
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.total_length = 16'd0;
    bus.val_done = 1'b0;
    bus.val_invalid = 1'b0;
    bus.parse_done = 1'b0;
    bus.parse_num_count = 11'd0;
    bus.conv_result_valid = 1'b0;
    bus.conv_result = 32'd0;
    bus.conv_error = 1'b0;
    test_reset();
    test_normal();
    test_invalid();
    test_overflow();
    test_same_cycle();
    test_stall();
    test_abort();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
